// File: rtl/sr_74595_framebuf.sv
// sr_74595_framebuf
// Double-buffered row bitmap store feeding the 74595 scan driver.
// A producer fills the back buffer row by row, then requests a commit.
// The buffers swap only on a scanner frame_start pulse, so the display
// never shows a half-updated frame. With COPY_ON_SWAP=1 the freshly
// displayed front is copied into the new back buffer, one row per cycle,
// so the producer can patch single rows on top of the current image.

module sr_74595_framebuf #(
  parameter int ROWS         = 4,
  parameter int COLS         = 8,
  parameter int COPY_ON_SWAP = 1,
  localparam int RW          = $clog2(ROWS)
) (
  input  logic            clk_16mhz,
  input  logic            rst_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            wr_commit,
  input  logic            frame_start,
  input  logic [RW-1:0]   rd_row,
  output logic [COLS-1:0] rd_data,
  output logic            swap_done,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COPY    = 2'd2
  } state_t;

  // Control state
  state_t          state_q, state_d;
  logic [RW-1:0]   cnt_q, cnt_d;
  logic            front_sel_q, front_sel_d;

  // Registered outputs
  logic [COLS-1:0] rd_data_q;
  logic            wr_ready_q, wr_ready_d;
  logic            busy_q, busy_d;
  logic            swap_done_q, swap_done_d;

  // Storage: buf0/buf1, front is selected by front_sel_q
  logic [COLS-1:0] buf0_q [ROWS];
  logic [COLS-1:0] buf1_q [ROWS];

  // Back-buffer write port (producer write or copy step)
  logic            back_we_s;
  logic [RW-1:0]   back_row_s;
  logic [COLS-1:0] back_data_s;
  logic [COLS-1:0] copy_src_s;
  logic [COLS-1:0] front_rd_s;

  // Front-buffer row being copied during COPY
  always_comb begin
    if (front_sel_q) begin
      copy_src_s = buf1_q[cnt_q];
    end else begin
      copy_src_s = buf0_q[cnt_q];
    end
  end

  // Front-buffer row requested by the scanner
  always_comb begin
    if (front_sel_q) begin
      front_rd_s = buf1_q[rd_row];
    end else begin
      front_rd_s = buf0_q[rd_row];
    end
  end

  // Next-state logic: commit handshake, frame-aligned swap, copy sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    front_sel_d = front_sel_q;
    swap_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A frame_start arriving with the commit is deliberately ignored:
        // the swap must wait for a frame boundary seen after acceptance.
        if (wr_commit) begin
          state_d = ST_PENDING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (frame_start) begin
          front_sel_d = ~front_sel_q;
          swap_done_d = 1'b1;
          cnt_d       = {RW{1'b0}};
          if (COPY_ON_SWAP != 0) begin
            state_d = ST_COPY;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_PENDING;
        end
      end
      ST_COPY: begin
        // frame_start is ignored here; exactly ROWS cycles are spent copying
        cnt_d = cnt_q + RW'(1);
        if (cnt_q == RW'(ROWS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_COPY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {RW{1'b0}};
      end
    endcase
  end

  // Back-buffer write selection: producer writes in IDLE, copy in COPY
  always_comb begin
    back_we_s   = 1'b0;
    back_row_s  = wr_row;
    back_data_s = wr_data;
    case (state_q)
      ST_IDLE: begin
        if (wr_valid) begin
          back_we_s = 1'b1;
        end else begin
          back_we_s = 1'b0;
        end
      end
      ST_COPY: begin
        back_we_s   = 1'b1;
        back_row_s  = cnt_q;
        back_data_s = copy_src_s;
      end
      default: begin
        back_we_s = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so the flags are registered
  always_comb begin
    wr_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {RW{1'b0}};
      front_sel_q <= 1'b0;
      rd_data_q   <= {COLS{1'b0}};
      wr_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      front_sel_q <= front_sel_d;
      // Reads use the front selection before any swap on this edge
      rd_data_q   <= front_rd_s;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      swap_done_q <= swap_done_d;
    end
  end

  // Buffer storage: only the back buffer is ever written
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        buf0_q[r] <= {COLS{1'b0}};
        buf1_q[r] <= {COLS{1'b0}};
      end
    end else begin
      if (back_we_s) begin
        if (front_sel_q) begin
          buf0_q[back_row_s] <= back_data_s;
        end else begin
          buf1_q[back_row_s] <= back_data_s;
        end
      end
    end
  end

  assign wr_ready  = wr_ready_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign swap_done = swap_done_q;

endmodule

// File: tb/tb_sr_74595_framebuf.sv
// Scoreboard bench for sr_74595_framebuf: two instances (copy on / copy off)
// share one stimulus stream; a frame-level reference model predicts outputs.

module tb_sr_74595_framebuf;

  localparam int ROWS = 4;
  localparam int COLS = 8;

  typedef struct {
    logic [COLS-1:0] rd;
    logic            rdy;
    logic            bsy;
    logic            sw;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_valid = 1'b0;
  logic [1:0]      wr_row = 2'd0;
  logic [COLS-1:0] wr_data = 8'h00;
  logic            wr_commit = 1'b0;
  logic            frame_start = 1'b0;
  logic [1:0]      rd_row = 2'd0;

  logic            wr_ready0, wr_ready1;
  logic [COLS-1:0] rd_data0, rd_data1;
  logic            swap_done0, swap_done1;
  logic            busy0, busy1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: [instance][buffer][row]; instance 0 copies on swap
  logic [COLS-1:0] mb [2][2][ROWS];
  int mf[2];
  int pend[2];
  int cleft[2];

  sr_74595_framebuf #(.ROWS(ROWS), .COLS(COLS), .COPY_ON_SWAP(1)) u_dut0 (
    .clk_16mhz(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready0),
    .wr_row(wr_row), .wr_data(wr_data), .wr_commit(wr_commit),
    .frame_start(frame_start), .rd_row(rd_row), .rd_data(rd_data0),
    .swap_done(swap_done0), .busy(busy0)
  );

  sr_74595_framebuf #(.ROWS(ROWS), .COLS(COLS), .COPY_ON_SWAP(0)) u_dut1 (
    .clk_16mhz(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready1),
    .wr_row(wr_row), .wr_data(wr_data), .wr_commit(wr_commit),
    .frame_start(frame_start), .rd_row(rd_row), .rd_data(rd_data1),
    .swap_done(swap_done1), .busy(busy1)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++) mb[k][b][r] = 8'h00;
      mf[k] = 0; pend[k] = 0; cleft[k] = 0;
    end
  endfunction

  // One clock edge of the model; returns outputs visible after that edge
  function automatic exp_t model_step(input int k, input logic v, input logic [1:0] row,
                                      input logic [COLS-1:0] d, input logic c,
                                      input logic fs, input logic [1:0] rr);
    exp_t e;
    e.rd = mb[k][mf[k]][rr];
    e.sw = 1'b0;
    if (pend[k] == 0 && cleft[k] == 0) begin
      if (v) mb[k][1 - mf[k]][row] = d;
      if (c) pend[k] = 1;
    end else if (pend[k] != 0) begin
      if (fs) begin
        mf[k] = 1 - mf[k];
        e.sw = 1'b1;
        pend[k] = 0;
        if (k == 0) begin
          for (int r = 0; r < ROWS; r++) mb[k][1 - mf[k]][r] = mb[k][mf[k]][r];
          cleft[k] = ROWS;
        end
      end
    end else begin
      cleft[k] = cleft[k] - 1;
    end
    e.rdy = (pend[k] == 0 && cleft[k] == 0);
    e.bsy = !e.rdy;
    return e;
  endfunction

  task automatic step(input logic v, input logic [1:0] row, input logic [COLS-1:0] d,
                      input logic c, input logic fs, input logic [1:0] rr);
    @(negedge clk);
    rst_n = 1'b1; wr_valid = v; wr_row = row; wr_data = d;
    wr_commit = c; frame_start = fs; rd_row = rr;
    q0.push_back(model_step(0, v, row, d, c, fs, rr));
    q1.push_back(model_step(1, v, row, d, c, fs, rr));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'(i));
  endtask

  task automatic rst_step(input logic [1:0] rr);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0; wr_valid = 1'b1; wr_row = rr; wr_data = 8'hA5;
    wr_commit = 1'b1; frame_start = 1'b1; rd_row = rr;
    model_reset();
    e.rd = 8'h00; e.rdy = 1'b1; e.bsy = 1'b0; e.sw = 1'b0;
    q0.push_back(e);
    q1.push_back(e);
    @(posedge clk);
  endtask

  // Directed read with constant expectations for both instances
  task automatic rd_expect(input logic [1:0] r, input logic [COLS-1:0] e0,
                           input logic [COLS-1:0] e1);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, r);
    #1;
    checks++;
    if (rd_data0 !== e0) begin
      errors++;
      $display("FAIL directed_rd copy1 row%0d got %h exp %h", r, rd_data0, e0);
    end
    checks++;
    if (rd_data1 !== e1) begin
      errors++;
      $display("FAIL directed_rd copy0 row%0d got %h exp %h", r, rd_data1, e1);
    end
  endtask

  task automatic cmp(input int k, input exp_t e, input logic [COLS-1:0] rd,
                     input logic rdy, input logic bsy, input logic sw);
    checks++;
    if (rd !== e.rd || rdy !== e.rdy || bsy !== e.bsy || sw !== e.sw) begin
      errors++;
      $display("FAIL sb inst%0d t=%0t got rd=%h rdy=%b busy=%b swap=%b exp rd=%h rdy=%b busy=%b swap=%b",
               k, $time, rd, rdy, bsy, sw, e.rd, e.rdy, e.bsy, e.sw);
    end
  endtask

  // Monitor: pops one expectation per instance after every active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp(0, e, rd_data0, wr_ready0, busy0, swap_done0);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp(1, e, rd_data1, wr_ready1, busy1, swap_done1);
      end
    end
  end

  logic [COLS-1:0] pat [ROWS];

  initial begin
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h44; pat[3] = 8'h88;
    model_reset();

    // Reset held with a write request present
    for (int i = 0; i < 4; i++) rst_step(2'(i));

    // Writes without commit never reach the front
    for (int r = 0; r < ROWS; r++) step(1'b1, 2'(r), pat[r], 1'b0, 1'b0, 2'(r));
    for (int r = 0; r < ROWS; r++) rd_expect(2'(r), 8'h00, 8'h00);

    // Commit, frame_start ten cycles later, new image visible
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0);
    idle(10);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0);
    idle(6);
    for (int r = 0; r < ROWS; r++) rd_expect(2'(r), pat[r], pat[r]);

    // Patch one row; copy-on-swap keeps the rest, no-copy shows stale back
    step(1'b1, 2'd2, 8'hF0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0);
    idle(3);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0);
    idle(6);
    rd_expect(2'd0, 8'h11, 8'h00);
    rd_expect(2'd1, 8'h22, 8'h00);
    rd_expect(2'd2, 8'hF0, 8'hF0);
    rd_expect(2'd3, 8'h88, 8'h00);

    // Commit with coincident frame_start, write while pending is dropped
    step(1'b1, 2'd0, 8'h5A, 1'b0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd0);
    step(1'b1, 2'd1, 8'hEE, 1'b0, 1'b0, 2'd0);
    idle(3);
    rd_expect(2'd0, 8'h11, 8'h00);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0);
    idle(6);
    rd_expect(2'd0, 8'h5A, 8'h5A);
    rd_expect(2'd1, 8'h22, 8'h22);

    // Reset during copy at row 1
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0);
    idle(2);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0);
    idle(1);
    rst_step(2'd1);
    rst_step(2'd2);
    for (int r = 0; r < ROWS; r++) rd_expect(2'(r), 8'h00, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        rst_step(2'($urandom_range(3)));
      end else begin
        step(1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom_range(255)),
             ($urandom_range(9) == 0), ($urandom_range(7) == 0), 2'($urandom_range(3)));
      end
    end

    idle(3);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d/%0d left exp 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
